alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer that drives an external 8-bit 74181-style ALU through its S/M/CN/A/B inputs and collects F/CO. It provides three operations: 8x8 unsigned shift-and-add multiply, 16-bit add, and 16-bit subtract. These are built from repeated single-cycle ALU passes. It sits between a requester (START/DONE handshake) and the shared combinational ALU instance, and owns the ALU for the whole operation.

## Interface
- No parameters; all widths fixed (8-bit ALU, 16-bit result).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- OP  in  2  00 = MUL, 01 = ADD16, 10 = SUB16, 11 = reserved.
- OPA  in  16  operand A (MUL uses OPA[7:0] as multiplicand).
- OPB  in  16  operand B (MUL uses OPB[7:0] as multiplier).
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse; RES/CY/ZERO valid from this cycle.
- RES  out  16  result register.
- CY  out  1  ADD16 carry-out / SUB16 borrow-out; 0 for MUL.
- ZERO  out  1  1 when RES == 16'h0000 (computed locally).
- ALU_S  out  4  ALU function select.
- ALU_M  out  1  ALU mode (0 arithmetic, 1 logic).
- ALU_CN  out  1  ALU carry/borrow in.
- ALU_A, ALU_B  out  8  ALU operands.
- ALU_F  in  8  ALU result.
- ALU_CO  in  1  ALU bit-8 (carry for add, borrow for subtract).
- ALU_FZ  in  1  ALU flag; ignored. It tests the 9-bit result and is 1 for non-zero, so it is unusable as a zero flag.

## Operation
- States: IDLE, MUL_RUN, ADD_LO, ADD_HI, FIN.
- IDLE:
  - ALU driven to pass-zero: S=1111, M=1, CN=0, A=0, B=0.
  - On START=1, capture OPA/OPB/OP into internal registers.
  - Next state: MUL_RUN if OP=00, ADD_LO if OP=01/10, FIN if OP=11.
- MUL_RUN (8 cycles, 3-bit counter):
  - Registers: acc[7:0], initialised to 0; lo[7:0], initialised to OPB[7:0]; mcand = OPA[7:0].
  - ALU_A = acc, ALU_B = mcand, CN = 0.
  - If lo[0] = 1, drive S=1001, M=0 (A+B). Otherwise drive S=1111, M=1 (F=A, CO=0).
  - Each cycle: acc <= {ALU_CO, ALU_F[7:1]}; lo <= {ALU_F[0], lo[7:1]}.
  - After the 8th cycle: RES <= {acc_next, lo_next}, CY <= 0; go to FIN.
- ADD_LO:
  - ALU_A = OPA[7:0], ALU_B = OPB[7:0], CN = 0.
  - ADD16 drives S=1001, M=0. SUB16 drives S=0110, M=0 (A-B-CN).
  - Latch RES[7:0] <= ALU_F and c <= ALU_CO.
- ADD_HI:
  - Same S/M as ADD_LO; ALU_A = OPA[15:8], ALU_B = OPB[15:8], CN = c.
  - RES[15:8] <= ALU_F, CY <= ALU_CO; go to FIN.
- Reserved OP (11): RES <= 0, CY <= 0.
- FIN:
  - DONE = 1, BUSY = 0; ZERO reflects the final RES.
  - ALU driven to pass-zero.
  - Unconditional return to IDLE; START is ignored in this cycle.
- RES, CY and ZERO hold until the next operation's final write. Intermediate RES[7:0] writes in ADD_LO are allowed.
- START is ignored while BUSY=1 or in FIN; operand changes after capture have no effect.
- Width rules:
  - ADD16 result is modulo 2^16; CY is the 17th bit.
  - SUB16 CY = 1 iff OPA < OPB (unsigned).
  - MUL result is exact, 16 bits.

## Timing
- Reset (any state, including mid-operation) gives: IDLE; BUSY=0, DONE=0, RES=0, CY=0, ZERO=0; counter and internal registers cleared; ALU pass-zero.
- ZERO is 0 after reset even though RES=0; it becomes valid from the first DONE.
- Let START be sampled in cycle 0:
  - MUL: BUSY=1 in cycles 1-8, DONE=1 in cycle 9.
  - ADD16/SUB16: BUSY=1 in cycles 1-2, DONE=1 in cycle 3.
  - Reserved: DONE=1 in cycle 1.
- Earliest next START accepted: cycle after DONE (back-to-back throughput: MUL 10 cycles, ADD 4 cycles).
- ALU_* outputs are combinational from state/registers. The ALU path is combinational and must settle within one CLK period.

## Test plan
- Reset mid-MUL: assert RST in cycle 4 of MUL_RUN -> next cycle BUSY=0, RES=0, CY=0, ZERO=0; a later START with OP=00, OPA=3, OPB=5 -> DONE at cycle 9, RES=0x000F.
- MUL extremes:
  - OPA=0xFF, OPB=0xFF -> RES=0xFE01, CY=0, ZERO=0, DONE exactly 9 cycles after START.
  - OPA=0x00, OPB=0xA5 -> RES=0, ZERO=1.
- ADD16 carry chain: OPA=0x00FF, OPB=0x0001 -> RES=0x0100, CY=0; OPA=0xFFFF, OPB=0x0001 -> RES=0x0000, CY=1, ZERO=1, DONE at cycle 3.
- SUB16 borrow: OPA=0x0000, OPB=0x0001 -> RES=0xFFFF, CY=1; OPA=0x1234, OPB=0x0234 -> RES=0x1000, CY=0.
- Handshake:
  - START held high continuously with OP=01 -> one operation per 4 cycles; START pulses during BUSY/FIN ignored.
  - OPA changed during BUSY -> result unaffected.
  - OP=11 -> DONE at cycle 1, RES=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencer that borrows an external 8-bit 74181-style ALU to build an 8x8 multiply
// and 16-bit add/subtract out of repeated single-cycle ALU passes.
module alu_seq_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [15:0] OPA,
  input  logic [15:0] OPB,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RES,
  output logic        CY,
  output logic        ZERO,
  output logic [3:0]  ALU_S,
  output logic        ALU_M,
  output logic        ALU_CN,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  input  logic [7:0]  ALU_F,
  input  logic        ALU_CO,
  input  logic        ALU_FZ
);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [3:0] S_ADD  = 4'b1001;
  localparam logic [3:0] S_SUB  = 4'b0110;
  localparam logic [3:0] S_PASS = 4'b1111;

  typedef enum logic [2:0] {IDLE, MUL_RUN, ADD_LO, ADD_HI, FIN} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [7:0]  acc, lo;
  logic [2:0]  cnt;
  logic        c;
  logic [15:0] res;
  logic        cy, zero;
  logic [7:0]  mul_acc_nxt, mul_lo_nxt;
  logic [3:0]  arith_s;

  // FZ is a non-zero flag over the 9-bit result, so zero detection is done locally.
  logic unused_fz;
  assign unused_fz = ALU_FZ;

  assign mul_acc_nxt = {ALU_CO, ALU_F[7:1]};
  assign mul_lo_nxt  = {ALU_F[0], lo[7:1]};
  assign arith_s     = req.op[1] ? S_SUB : S_ADD;

  assign BUSY = (state == MUL_RUN) || (state == ADD_LO) || (state == ADD_HI);
  assign DONE = (state == FIN);
  assign RES  = res;
  assign CY   = cy;
  assign ZERO = zero;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      req   <= '0;
      acc   <= '0;
      lo    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      res   <= '0;
      cy    <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (START) begin
          req.op <= OP;
          req.a  <= OPA;
          req.b  <= OPB;
          acc    <= '0;
          lo     <= OPB[7:0];
          cnt    <= '0;
          if (OP == OP_RSV) begin
            res  <= '0;
            cy   <= 1'b0;
            zero <= 1'b1;
          end
        end
        MUL_RUN: begin
          acc <= mul_acc_nxt;
          lo  <= mul_lo_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            res  <= {mul_acc_nxt, mul_lo_nxt};
            cy   <= 1'b0;
            zero <= ~|{mul_acc_nxt, mul_lo_nxt};
          end
        end
        ADD_LO: begin
          res[7:0] <= ALU_F;
          c        <= ALU_CO;
        end
        ADD_HI: begin
          res[15:8] <= ALU_F;
          cy        <= ALU_CO;
          zero      <= ~|{ALU_F, res[7:0]};
        end
        default: ;
      endcase
    end
  end

  // Outputs default to ALU pass-zero; each busy state overrides what it uses.
  always_comb begin
    state_nxt = state;
    ALU_S     = S_PASS;
    ALU_M     = 1'b1;
    ALU_CN    = 1'b0;
    ALU_A     = '0;
    ALU_B     = '0;
    case (state)
      IDLE: if (START) begin
        if (OP == OP_MUL)      state_nxt = MUL_RUN;
        else if (OP == OP_RSV) state_nxt = FIN;
        else                   state_nxt = ADD_LO;
      end
      MUL_RUN: begin
        ALU_A = acc;
        ALU_B = req.a[7:0];
        if (lo[0]) begin
          ALU_S = S_ADD;
          ALU_M = 1'b0;
        end
        if (cnt == 3'd7) state_nxt = FIN;
      end
      ADD_LO: begin
        ALU_S     = arith_s;
        ALU_M     = 1'b0;
        ALU_A     = req.a[7:0];
        ALU_B     = req.b[7:0];
        state_nxt = ADD_HI;
      end
      ADD_HI: begin
        ALU_S     = arith_s;
        ALU_M     = 1'b0;
        ALU_CN    = c;
        ALU_A     = req.a[15:8];
        ALU_B     = req.b[15:8];
        state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 74181 subset, directed vector table, multi-cycle
// corner sequences and random operations checked against an arithmetic reference.
module tb_alu_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [1:0]  OP;
  logic [15:0] OPA, OPB;
  logic        BUSY, DONE, CY, ZERO;
  logic [15:0] RES;
  logic [3:0]  ALU_S;
  logic        ALU_M, ALU_CN;
  logic [7:0]  ALU_A, ALU_B, ALU_F;
  logic        ALU_CO, ALU_FZ;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .BUSY(BUSY), .DONE(DONE), .RES(RES), .CY(CY), .ZERO(ZERO),
    .ALU_S(ALU_S), .ALU_M(ALU_M), .ALU_CN(ALU_CN), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_F(ALU_F), .ALU_CO(ALU_CO), .ALU_FZ(ALU_FZ)
  );

  always #5 CLK = ~CLK;

  // External ALU: only the three functions the sequencer should ever select.
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'h0A5;
    case ({ALU_M, ALU_S})
      5'b0_1001: alu_t = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CN};
      5'b0_0110: alu_t = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_CN};
      5'b1_1111: alu_t = {1'b0, ALU_A};
      default:   alu_t = 9'h0A5;
    endcase
    ALU_F  = alu_t[7:0];
    ALU_CO = alu_t[8];
    ALU_FZ = |alu_t;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic meaning of each op and its documented latency.
  task automatic ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic cy, output int lat);
    logic [16:0] s;
    case (op)
      2'b00: begin res = 16'(a[7:0] * b[7:0]); cy = 1'b0; lat = 9; end
      2'b01: begin s = {1'b0, a} + {1'b0, b}; res = s[15:0]; cy = s[16]; lat = 3; end
      2'b10: begin res = a - b; cy = (a < b); lat = 3; end
      default: begin res = 16'h0; cy = 1'b0; lat = 1; end
    endcase
  endtask

  // Starts an op from IDLE, scrambles inputs and pulses START while busy, then checks.
  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res, input logic exp_cy,
                        input int lat);
    int cycles, busy_cnt;
    @(negedge CLK);
    chk({name, ".idle_busy"}, BUSY, 1'b0);
    START = 1'b1; OP = op; OPA = a; OPB = b;
    @(negedge CLK);
    cycles = 1; busy_cnt = 0;
    OP = ~op; OPA = ~a; OPB = b ^ 16'h5A5A;
    while (!DONE && cycles < 20) begin
      if (BUSY) busy_cnt++;
      START = 1'($urandom_range(0, 1));
      @(negedge CLK);
      cycles++;
    end
    chk({name, ".done_seen"}, DONE, 1'b1);
    chk({name, ".latency"}, cycles, lat);
    chk({name, ".busy_cycles"}, busy_cnt, lat - 1);
    chk({name, ".busy_at_done"}, BUSY, 1'b0);
    chk({name, ".res"}, RES, exp_res);
    chk({name, ".cy"}, CY, exp_cy);
    chk({name, ".zero"}, ZERO, exp_res == 16'h0);
    START = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".busy"}, BUSY, 1'b0);
    chk({name, ".done"}, DONE, 1'b0);
    chk({name, ".res"}, RES, 16'h0);
    chk({name, ".cy"}, CY, 1'b0);
    chk({name, ".zero"}, ZERO, 1'b0);
    chk({name, ".alu"}, {ALU_S, ALU_M, ALU_CN, ALU_A, ALU_B}, {4'hF, 1'b1, 1'b0, 16'h0});
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [15:0] res;
    logic        cy;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] r;
    logic        c;
    int          lat;
    logic [11:0] done_map, exp_map;

    vecs[0] = '{"mul_ff_ff",   2'b00, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 9};
    vecs[1] = '{"mul_0_a5",    2'b00, 16'h0000, 16'h00A5, 16'h0000, 1'b0, 9};
    vecs[2] = '{"mul_hi_bits", 2'b00, 16'hAB80, 16'hCD02, 16'h0100, 1'b0, 9};
    vecs[3] = '{"add_ff_1",    2'b01, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3};
    vecs[4] = '{"add_ffff_1",  2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3};
    vecs[5] = '{"sub_0_1",     2'b10, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3};
    vecs[6] = '{"sub_1234",    2'b10, 16'h1234, 16'h0234, 16'h1000, 1'b0, 3};
    vecs[7] = '{"mul_1_ff",    2'b00, 16'h0001, 16'h00FF, 16'h00FF, 1'b0, 9};
    vecs[8] = '{"rsv",         2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1};
    vecs[9] = '{"sub_eq",      2'b10, 16'h8001, 16'h8001, 16'h0000, 1'b0, 3};

    RST = 1'b1; START = 1'b0; OP = 2'b00; OPA = '0; OPB = '0;
    repeat (3) @(negedge CLK);
    chk_reset_state("reset");
    RST = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cy, vecs[i].lat);

    // Reset in the 4th MUL_RUN cycle after a result with CY=1 and ZERO=1 is held.
    run_op("pre_rst_add", 2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3);
    @(negedge CLK);
    START = 1'b1; OP = 2'b00; OPA = 16'h0077; OPB = 16'h0033;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_mul.busy_before_rst", BUSY, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_state("mid_mul_rst");
    run_op("after_rst_mul", 2'b00, 16'h0003, 16'h0005, 16'h000F, 1'b0, 9);

    // START held high with ADD16: one DONE every 4 cycles, at cycles 3, 7, 11.
    @(negedge CLK);
    START = 1'b1; OP = 2'b01; OPA = 16'h0001; OPB = 16'h0002;
    done_map = '0; exp_map = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      done_map[k-1] = DONE;
      exp_map[k-1]  = (k % 4 == 3);
    end
    START = 1'b0;
    chk("start_held.done_map", done_map, exp_map);
    chk("start_held.res", RES, 16'h0003);
    @(negedge CLK);
    @(negedge CLK);
    chk("start_held.idle", {BUSY, DONE}, 2'b00);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [15:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (n % 8 == 0) b = a;
      ref_op(op, a, b, r, c, lat);
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, r, c, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
